// File: rtl/ifetch_queue_if.sv
// Fetch-stage bundle: redirect input, instruction-memory port and decode handshake.
// master is the fetch unit; slave is the memory/decode environment around it.
interface ifetch_queue_if #(
    parameter int unsigned WORD_W  = 64,
    parameter int unsigned INSTR_W = 32
);
    logic               pc_src;
    logic [WORD_W-1:0]  branch_target;
    logic               imem_req;
    logic [WORD_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instruction;
    logic [WORD_W-1:0]  cur_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        input  pc_src, branch_target, imem_rdata, instr_ready,
        output imem_req, imem_addr, instruction, cur_pc, instr_valid
    );

    modport slave (
        output pc_src, branch_target, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instruction, cur_pc, instr_valid
    );
endinterface

// File: rtl/ifetch_queue.sv
// Prefetching fetch stage: fixed-latency imem requests feed a DEPTH-entry {pc, instr}
// queue drained by decode; a redirect flushes both queued and in-flight work.
module ifetch_queue #(
    parameter int unsigned       WORD_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input logic            clk,
    input logic            reset,
    ifetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [WORD_W-1:0] ALIGN_MASK = ~(WORD_W'(PC_STEP - 1));

    logic [WORD_W-1:0]  fetch_pc_q;
    logic               inflight_q;
    logic [WORD_W-1:0]  inflight_pc_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [WORD_W-1:0]  mem_pc_q    [DEPTH];
    logic [INSTR_W-1:0] mem_instr_q [DEPTH];

    logic             issue, push, pop;
    logic [CNT_W:0]   credit_used;

    // Credit counts the in-flight response so its slot is always reserved.
    always_comb begin
        credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        issue       = !reset && !bus.pc_src && (credit_used < (CNT_W + 1)'(DEPTH));
        push        = inflight_q && !bus.pc_src;
        pop         = (count_q != '0) && bus.instr_ready;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instruction = mem_instr_q[rd_ptr_q];
    assign bus.cur_pc      = mem_pc_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else if (bus.pc_src) begin
            // A pop in this cycle still completes downstream; everything else is dropped.
            fetch_pc_q <= bus.branch_target & ALIGN_MASK;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                fetch_pc_q    <= fetch_pc_q + WORD_W'(PC_STEP);
                inflight_pc_q <= fetch_pc_q;
            end
            if (push) begin
                mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
                mem_instr_q[wr_ptr_q] <= bus.imem_rdata;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == CNT_W'(DEPTH))));
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a scoreboard of issued {pc, instr} pairs is checked
// against every accepted head, alongside directed latency/backpressure/redirect checks.
module tb_ifetch_queue;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    logic        s_req, s_valid;
    logic [63:0] s_addr, s_pc;
    logic [31:0] s_instr;

    ifetch_queue_if #(.WORD_W(64), .INSTR_W(32)) bus_if ();

    ifetch_queue #(
        .WORD_W(64), .INSTR_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(64'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory: data for a request appears exactly one cycle later.
    always @(posedge clk) begin
        bus_if.imem_rdata <= bus_if.imem_req ? pat(bus_if.imem_addr) : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle starting at a falling edge: drive, sample, score, advance.
    task automatic cycle(input logic src, input logic [63:0] tgt, input logic rdy);
        exp_t e;
        bus_if.pc_src        = src;
        bus_if.branch_target = tgt;
        bus_if.instr_ready   = rdy;
        #1;
        s_req   = bus_if.imem_req;
        s_addr  = bus_if.imem_addr;
        s_valid = bus_if.instr_valid;
        s_pc    = bus_if.cur_pc;
        s_instr = bus_if.instruction;
        if (s_req) exp_q.push_back('{pc: s_addr, instr: pat(s_addr)});
        if (s_valid && rdy) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", s_pc, e.pc);
                check("sb_instr", 64'(s_instr), 64'(e.instr));
            end
        end
        if (src) exp_q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.pc_src = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic seen;
        reset                = 1'b1;
        bus_if.pc_src        = 1'b0;
        bus_if.branch_target = '0;
        bus_if.instr_ready   = 1'b1;
        #1;
        check("rst_valid", 64'(bus_if.instr_valid), 64'd0);
        check("rst_req", 64'(bus_if.imem_req), 64'd0);
        check("rst_instr", 64'(bus_if.instruction), 64'd0);
        check("rst_pc", bus_if.cur_pc, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming: 0,4,8,... with two-cycle latency and no bubbles.
        cycle(1'b0, 64'd0, 1'b1);
        check("a_req0", 64'(s_req), 64'd1);
        check("a_addr0", s_addr, 64'd0);
        check("a_valid0", 64'(s_valid), 64'd0);
        cycle(1'b0, 64'd0, 1'b1);
        check("a_addr1", s_addr, 64'd4);
        check("a_valid1", 64'(s_valid), 64'd0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 64'd0, 1'b1);
            check("a_nogap", 64'(s_valid), 64'd1);
        end

        // Asynchronous reset between edges drops outputs immediately.
        #3;
        reset = 1'b1;
        #1;
        check("ar_valid", 64'(bus_if.instr_valid), 64'd0);
        check("ar_req", 64'(bus_if.imem_req), 64'd0);
        check("ar_pc", bus_if.cur_pc, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();

        // Backpressure: exactly four entries fill, then drain in order and resume at 16.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 64'd0, 1'b0);
            check("bp_req", 64'(s_req), 64'd1);
            check("bp_addr", s_addr, 64'(i * 4));
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 64'd0, 1'b0);
            check("bp_stall", 64'(s_req), 64'd0);
        end
        check("bp_head_valid", 64'(s_valid), 64'd1);
        check("bp_head_pc", s_pc, 64'd0);
        check("bp_head_instr", 64'(s_instr), 64'(pat(64'd0)));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 64'd0, 1'b1);
            if (s_req && !seen) begin
                seen = 1'b1;
                check("bp_resume_addr", s_addr, 64'd16);
            end
        end
        check("bp_resume_seen", 64'(seen), 64'd1);

        // Redirect with three queued and one in flight.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b0);
        cycle(1'b1, 64'h100, 1'b0);
        check("rd_req_r", 64'(s_req), 64'd0);
        cycle(1'b0, 64'd0, 1'b1);
        check("rd_valid_r1", 64'(s_valid), 64'd0);
        check("rd_req_r1", 64'(s_req), 64'd1);
        check("rd_addr_r1", s_addr, 64'h100);
        cycle(1'b0, 64'd0, 1'b1);
        check("rd_valid_r2", 64'(s_valid), 64'd0);
        cycle(1'b0, 64'd0, 1'b1);
        check("rd_valid_r3", 64'(s_valid), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b1);

        // Misaligned target plus a pop in the redirect cycle.
        cycle(1'b1, 64'h103, 1'b1);
        check("mis_pop_valid", 64'(s_valid), 64'd1);
        cycle(1'b0, 64'd0, 1'b1);
        check("mis_valid", 64'(s_valid), 64'd0);
        check("mis_addr", s_addr, 64'h100);
        for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b1);

        // Back-to-back redirects: the second one wins.
        cycle(1'b1, 64'h200, 1'b1);
        cycle(1'b1, 64'h300, 1'b1);
        cycle(1'b0, 64'd0, 1'b1);
        check("b2b_addr", s_addr, 64'h300);
        for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b1);

        // Wrap of the fetch PC across the top of the address space.
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        cycle(1'b0, 64'd0, 1'b1);
        check("wrap_addr0", s_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        cycle(1'b0, 64'd0, 1'b1);
        check("wrap_addr1", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b0, 64'd0, 1'b1);
        check("wrap_addr2", s_addr, 64'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 64'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
